// File: rtl/lvds_video_pkg.sv
// rtl/lvds_video_pkg.sv - shared 21-bit LVDS word map, lock FSM states and counter width
package lvds_video_pkg;

  localparam int CNT_W_DEF = 11;

  // Bit positions inside the 21-bit deserialized word (shared with the transmitter)
  localparam int BIT_B2 = 20;
  localparam int BIT_B3 = 19;
  localparam int BIT_B4 = 18;
  localparam int BIT_B5 = 17;
  localparam int BIT_HS = 16;
  localparam int BIT_VS = 15;
  localparam int BIT_DE = 14;
  localparam int BIT_G1 = 13;
  localparam int BIT_G2 = 12;
  localparam int BIT_G3 = 11;
  localparam int BIT_G4 = 10;
  localparam int BIT_G5 = 9;
  localparam int BIT_B0 = 8;
  localparam int BIT_B1 = 7;
  localparam int BIT_R0 = 6;
  localparam int BIT_R1 = 5;
  localparam int BIT_R2 = 4;
  localparam int BIT_R3 = 3;
  localparam int BIT_R4 = 2;
  localparam int BIT_R5 = 1;
  localparam int BIT_G0 = 0;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } lock_state_e;

endpackage

// File: rtl/lvds_video_decoder_meas.sv
// rtl/lvds_video_decoder_meas.sv - sync edge detection, per-frame timing counters and consistency flag
module lvds_timing_meas #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hs_i,
  input  logic             vs_i,
  input  logic             de_i,
  input  logic             hs_prev_i,
  input  logic             vs_prev_i,
  input  logic             de_prev_i,
  output logic             vs_fall_o,
  output logic             de_rise_o,
  output logic             de_fall_o,
  output logic             done_o,
  output logic             frm_ok_o,
  output logic [CNT_W-1:0] frm_width_o,
  output logic [CNT_W-1:0] frm_htot_o,
  output logic [CNT_W-1:0] frm_height_o,
  output logic [CNT_W-1:0] frm_vtot_o
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CMAX) ? v : v + 1'b1;
  endfunction

  logic vs_fall, de_rise, de_fall, hs_fall;
  logic [CNT_W-1:0] run_q, run_d, hcnt_q, hcnt_d, height_q, height_d, vtot_q, vtot_d;
  logic [CNT_W-1:0] ref_w_q, ref_w_d, ref_h_q, ref_h_d;
  logic have_w_q, have_w_d, have_h_q, have_h_d, seen_q, seen_d, bad_q, bad_d;
  logic done_q, ok_q;
  logic [CNT_W-1:0] fw_q, fh_q, fht_q, fvt_q;

  assign vs_fall = vs_prev_i & ~vs_i;
  assign de_rise = de_i & ~de_prev_i;
  assign de_fall = de_prev_i & ~de_i;
  assign hs_fall = hs_prev_i & ~hs_i;

  always_comb begin
    run_d    = run_q;
    hcnt_d   = sat_inc(hcnt_q);
    height_d = height_q;
    vtot_d   = vtot_q;
    ref_w_d  = ref_w_q;
    ref_h_d  = ref_h_q;
    have_w_d = have_w_q;
    have_h_d = have_h_q;
    seen_d   = seen_q;
    bad_d    = bad_q;
    if (de_rise) begin
      run_d  = ONE;
      hcnt_d = ONE;
    end else if (de_i) begin
      run_d = sat_inc(run_q);
    end
    // A line closing on the vs_fall cycle still belongs to the ending frame
    if (de_fall) begin
      if (run_q == CMAX) bad_d = 1'b1;
      if (!have_w_q) begin
        ref_w_d  = run_q;
        have_w_d = 1'b1;
      end else if (run_q != ref_w_q) begin
        bad_d = 1'b1;
      end
    end
    if (de_rise && !vs_fall) begin
      if (height_q == CMAX) bad_d = 1'b1;
      height_d = sat_inc(height_q);
      seen_d   = 1'b1;
      if (seen_q) begin
        if (hcnt_q == CMAX) bad_d = 1'b1;
        if (!have_h_q) begin
          ref_h_d  = hcnt_q;
          have_h_d = 1'b1;
        end else if (hcnt_q != ref_h_q) begin
          bad_d = 1'b1;
        end
      end
    end
    if (hs_fall) begin
      if (vtot_q == CMAX) bad_d = 1'b1;
      vtot_d = sat_inc(vtot_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_q <= '0; hcnt_q <= '0; height_q <= '0; vtot_q <= '0;
      ref_w_q <= '0; ref_h_q <= '0;
      have_w_q <= 1'b0; have_h_q <= 1'b0; seen_q <= 1'b0; bad_q <= 1'b0;
      done_q <= 1'b0; ok_q <= 1'b0;
      fw_q <= '0; fh_q <= '0; fht_q <= '0; fvt_q <= '0;
    end else if (vs_fall) begin
      done_q   <= 1'b1;
      ok_q     <= !bad_d && (height_d != '0);
      fw_q     <= ref_w_d;
      fht_q    <= ref_h_d;
      fh_q     <= height_d;
      fvt_q    <= vtot_d;
      run_q    <= run_d;
      hcnt_q   <= hcnt_d;
      height_q <= de_rise ? ONE : '0;
      seen_q   <= de_rise;
      vtot_q   <= '0;
      ref_w_q  <= '0;
      ref_h_q  <= '0;
      have_w_q <= 1'b0;
      have_h_q <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      run_q    <= run_d;
      hcnt_q   <= hcnt_d;
      height_q <= height_d;
      vtot_q   <= vtot_d;
      ref_w_q  <= ref_w_d;
      ref_h_q  <= ref_h_d;
      have_w_q <= have_w_d;
      have_h_q <= have_h_d;
      seen_q   <= seen_d;
      bad_q    <= bad_d;
    end
  end

  assign vs_fall_o    = vs_fall;
  assign de_rise_o    = de_rise;
  assign de_fall_o    = de_fall;
  assign done_o       = done_q;
  assign frm_ok_o     = ok_q;
  assign frm_width_o  = fw_q;
  assign frm_htot_o   = fht_q;
  assign frm_height_o = fh_q;
  assign frm_vtot_o   = fvt_q;

endmodule

// File: rtl/lvds_video_decoder.sv
// rtl/lvds_video_decoder.sv - LVDS 21-bit word unpack, pixel coordinates and frame-timing lock
// Optional per-pixel colour check and pix_err_cnt port under `PIXEL_CHECK_EN.
module lvds_video_decoder
  import lvds_video_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int LOCK_FRAMES    = 2,
  parameter int TIMEOUT_CYCLES = 2000000
`ifdef PIXEL_CHECK_EN
  ,
  parameter logic [5:0] EXP_R = 6'd63,
  parameter logic [5:0] EXP_G = 6'd0,
  parameter logic [5:0] EXP_B = 6'd0
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [20:0]      datain,
  output logic [5:0]       red_o,
  output logic [5:0]       green_o,
  output logic [5:0]       blue_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             frame_start,
  output logic             locked,
  output logic [CNT_W-1:0] active_width,
  output logic [CNT_W-1:0] active_height,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] v_total
`ifdef PIXEL_CHECK_EN
  ,
  output logic [15:0]      pix_err_cnt
`endif
);

  localparam logic [7:0]      LOCK_N  = 8'(LOCK_FRAMES);
  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [5:0] r_in, g_in, b_in;
  logic hs_in, vs_in, de_in;
  logic [5:0] r_q, g_q, b_q;
  logic hs_q, vs_q, de_q, fs_q;
  logic [CNT_W-1:0] px_q, py_q;
  logic vs_fall, de_rise, de_fall, done, frm_ok;
  logic [CNT_W-1:0] frm_w, frm_ht, frm_h, frm_vt;

  assign r_in  = {datain[BIT_R5], datain[BIT_R4], datain[BIT_R3],
                  datain[BIT_R2], datain[BIT_R1], datain[BIT_R0]};
  assign g_in  = {datain[BIT_G5], datain[BIT_G4], datain[BIT_G3],
                  datain[BIT_G2], datain[BIT_G1], datain[BIT_G0]};
  assign b_in  = {datain[BIT_B5], datain[BIT_B4], datain[BIT_B3],
                  datain[BIT_B2], datain[BIT_B1], datain[BIT_B0]};
  assign hs_in = datain[BIT_HS];
  assign vs_in = datain[BIT_VS];
  assign de_in = datain[BIT_DE];

  lvds_timing_meas #(.CNT_W(CNT_W)) u_meas (
    .clk          (clk),
    .rst          (rst),
    .hs_i         (hs_in),
    .vs_i         (vs_in),
    .de_i         (de_in),
    .hs_prev_i    (hs_q),
    .vs_prev_i    (vs_q),
    .de_prev_i    (de_q),
    .vs_fall_o    (vs_fall),
    .de_rise_o    (de_rise),
    .de_fall_o    (de_fall),
    .done_o       (done),
    .frm_ok_o     (frm_ok),
    .frm_width_o  (frm_w),
    .frm_htot_o   (frm_ht),
    .frm_height_o (frm_h),
    .frm_vtot_o   (frm_vt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= '0; g_q <= '0; b_q <= '0;
      hs_q <= 1'b1; vs_q <= 1'b1; de_q <= 1'b0; fs_q <= 1'b0;
      px_q <= '0; py_q <= '0;
    end else begin
      r_q  <= r_in;
      g_q  <= g_in;
      b_q  <= b_in;
      hs_q <= hs_in;
      vs_q <= vs_in;
      de_q <= de_in;
      fs_q <= vs_fall;
      if (de_rise) px_q <= '0;
      else if (de_in && px_q != '1) px_q <= px_q + 1'b1;
      if (vs_fall) py_q <= '0;
      else if (de_fall && py_q != '1) py_q <= py_q + 1'b1;
    end
  end

  lock_state_e state_q;
  logic [7:0] match_q, match_nx;
  logic [TO_W-1:0] to_q;
  logic locked_q, same_ref;
  logic [CNT_W-1:0] ref_w_q, ref_h_q, ref_ht_q, ref_vt_q;
  logic [CNT_W-1:0] act_w_q, act_h_q, act_ht_q, act_vt_q;

  assign same_ref = (frm_w == ref_w_q) && (frm_h == ref_h_q) &&
                    (frm_ht == ref_ht_q) && (frm_vt == ref_vt_q);

  always_comb begin
    match_nx = '0;
    if (frm_ok) match_nx = same_ref ? match_q + 8'd1 : 8'd1;
  end

  // Frame verdicts arrive on done, one cycle after the vs_fall that closed the frame
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_SEARCH; match_q <= '0; to_q <= '0; locked_q <= 1'b0;
      ref_w_q <= '0; ref_h_q <= '0; ref_ht_q <= '0; ref_vt_q <= '0;
      act_w_q <= '0; act_h_q <= '0; act_ht_q <= '0; act_vt_q <= '0;
    end else if (!vs_fall && to_q == TO_LAST) begin
      state_q <= ST_SEARCH; match_q <= '0; to_q <= '0; locked_q <= 1'b0;
      act_w_q <= '0; act_h_q <= '0; act_ht_q <= '0; act_vt_q <= '0;
    end else begin
      to_q <= vs_fall ? '0 : to_q + 1'b1;
      if (done) begin
        if (state_q == ST_SEARCH) begin
          state_q <= ST_MEASURE;
          match_q <= '0;
        end else if (!(state_q == ST_LOCKED && frm_ok && same_ref)) begin
          match_q <= match_nx;
          if (frm_ok && !same_ref) begin
            ref_w_q <= frm_w; ref_h_q <= frm_h; ref_ht_q <= frm_ht; ref_vt_q <= frm_vt;
          end
          if (frm_ok && match_nx >= LOCK_N) begin
            state_q  <= ST_LOCKED;
            locked_q <= 1'b1;
            act_w_q  <= frm_w; act_h_q <= frm_h; act_ht_q <= frm_ht; act_vt_q <= frm_vt;
          end else begin
            state_q  <= ST_MEASURE;
            locked_q <= 1'b0;
          end
        end
      end
    end
  end

`ifdef PIXEL_CHECK_EN
  logic [15:0] err_q;
  logic pix_bad;
  assign pix_bad = locked_q && de_in && ((r_in != EXP_R) || (g_in != EXP_G) || (b_in != EXP_B));

  // Completed-frame count is held on the frame_start cycle, then restarts
  always_ff @(posedge clk) begin
    if (!rst) err_q <= '0;
    else if (vs_fall) err_q <= err_q;
    else if (fs_q) err_q <= {15'd0, pix_bad};
    else if (pix_bad && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
  end
  assign pix_err_cnt = err_q;
`endif

  assign red_o         = r_q;
  assign green_o       = g_q;
  assign blue_o        = b_q;
  assign hsync_o       = hs_q;
  assign vsync_o       = vs_q;
  assign de_o          = de_q;
  assign pix_x         = px_q;
  assign pix_y         = py_q;
  assign frame_start   = fs_q;
  assign locked        = locked_q;
  assign active_width  = act_w_q;
  assign active_height = act_h_q;
  assign h_total       = act_ht_q;
  assign v_total       = act_vt_q;

endmodule

// File: tb/tb_lvds_video_decoder.sv
// tb/tb_lvds_video_decoder.sv - directed bench for lvds_video_decoder (PIXEL_CHECK_EN checks when defined)
module tb_lvds_video_decoder;

  logic        clk;
  logic        rst;
  logic [20:0] datain;
  logic [5:0]  red_o, green_o, blue_o;
  logic        hsync_o, vsync_o, de_o;
  logic [10:0] pix_x, pix_y;
  logic        frame_start, locked;
  logic [10:0] active_width, active_height, h_total, v_total;
`ifdef PIXEL_CHECK_EN
  logic [15:0] pix_err_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  lvds_video_decoder #(.CNT_W(11), .LOCK_FRAMES(2), .TIMEOUT_CYCLES(1000)) dut (
    .clk           (clk),
    .rst           (rst),
    .datain        (datain),
    .red_o         (red_o),
    .green_o       (green_o),
    .blue_o        (blue_o),
    .hsync_o       (hsync_o),
    .vsync_o       (vsync_o),
    .de_o          (de_o),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .frame_start   (frame_start),
    .locked        (locked),
    .active_width  (active_width),
    .active_height (active_height),
    .h_total       (h_total),
    .v_total       (v_total)
`ifdef PIXEL_CHECK_EN
    ,
    .pix_err_cnt   (pix_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input logic [20:0] w);
    datain = w;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [20:0] pack(input logic [5:0] r, input logic [5:0] g,
                                       input logic [5:0] b, input logic hs,
                                       input logic vs, input logic de);
    logic [20:0] w;
    w[20] = b[2]; w[19] = b[3]; w[18] = b[4]; w[17] = b[5];
    w[16] = hs;   w[15] = vs;   w[14] = de;
    w[13] = g[1]; w[12] = g[2]; w[11] = g[3]; w[10] = g[4]; w[9] = g[5];
    w[8]  = b[0]; w[7]  = b[1];
    w[6]  = r[0]; w[5]  = r[1]; w[4]  = r[2]; w[3]  = r[3]; w[2] = r[4]; w[1] = r[5];
    w[0]  = g[0];
    return w;
  endfunction

  // 11 lines x 24 clk; DE on cols 0..15 of lines 0..7, HS low cols 20..21, VS low lines 9..10
  task automatic send_frame(input int short_line, input int n_err,
                            input logic lk_pre, input logic lk_post,
                            input int ew, input int eh, input int et, input int ev,
                            input int e_err);
    logic de, hs, vs;
    logic [5:0] r, g;
    for (int l = 0; l < 11; l++) begin
      for (int c = 0; c < 24; c++) begin
        de = (l < 8) && (c < ((l == short_line) ? 15 : 16));
        hs = !(c >= 20 && c < 22);
        vs = (l < 9);
        r  = de ? 6'd63 : 6'd0;
        g  = (de && l == 2 && c < n_err) ? 6'd1 : 6'd0;
        step(pack(r, g, 6'd0, hs, vs, de));
        chk("frame_start", frame_start, (l == 9 && c == 0));
        if (de) chk("pix_xy", {pix_x, pix_y}, {c[10:0], l[10:0]});
        if (l == 9 && c == 0) chk("locked_at_vs_fall", locked, lk_pre);
        if (l == 9 && c == 1) begin
          chk("locked_after_vs_fall", locked, lk_post);
          chk("active_width", active_width, ew);
          chk("active_height", active_height, eh);
          chk("h_total", h_total, et);
          chk("v_total", v_total, ev);
        end
`ifdef PIXEL_CHECK_EN
        if (l == 9 && c == 0) chk("pix_err_frame", pix_err_cnt, e_err);
        if (l == 9 && c == 1) chk("pix_err_clear", pix_err_cnt, 0);
`endif
      end
    end
  endtask

  int map_tbl [0:20] = '{9, 20, 19, 18, 17, 16, 15, 4, 3, 14, 13, 12, 11, 10, 0, 1, 2, 8, 7, 6, 5};
  logic [20:0] one_hot;
  logic [20:0] idle;

  initial begin
    datain = '0;
    rst = 1'b0;
    step('0);
    step('0);
    chk("rst_hsync", hsync_o, 1);
    chk("rst_vsync", vsync_o, 1);
    chk("rst_rgb_de", {red_o, green_o, blue_o, de_o}, 0);
    chk("rst_pix", {pix_x, pix_y, frame_start, locked}, 0);
    chk("rst_meas_a", {active_width, active_height}, 0);
    chk("rst_meas_b", {h_total, v_total}, 0);
    rst = 1'b1;

    // R=0x2A G=0x15 B=0x33 HS=0 VS=1 DE=1
    step(21'h06D5AB);
    chk("map_red", red_o, 6'h2A);
    chk("map_green", green_o, 6'h15);
    chk("map_blue", blue_o, 6'h33);
    chk("map_hs", hsync_o, 0);
    chk("map_vs", vsync_o, 1);
    chk("map_de", de_o, 1);

    for (int i = 0; i < 21; i++) begin
      one_hot = 21'd1 << i;
      step(one_hot);
      chk("walk_one", {red_o, green_o, blue_o, hsync_o, vsync_o, de_o}, 21'd1 << map_tbl[i]);
    end

    rst = 1'b0;
    idle = pack(6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0);
    step(idle);
    step(idle);
    rst = 1'b1;

    send_frame(-1, 0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    send_frame(-1, 0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    send_frame(-1, 0, 1'b0, 1'b1, 16, 8, 24, 11, 0);
    send_frame(-1, 3, 1'b1, 1'b1, 16, 8, 24, 11, 3);
    send_frame(3, 0, 1'b1, 1'b0, 16, 8, 24, 11, 0);
    send_frame(-1, 0, 1'b0, 1'b0, 16, 8, 24, 11, 0);
    send_frame(-1, 0, 1'b0, 1'b1, 16, 8, 24, 11, 0);

    repeat (900) step(idle);
    chk("timeout_not_yet", locked, 1);
    repeat (100) step(idle);
    chk("timeout_locked", locked, 0);
    chk("timeout_meas_a", {active_width, active_height}, 0);
    chk("timeout_meas_b", {h_total, v_total}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
